// File: rtl/video_pattern_generator.sv
// Test-pattern source for display bring-up: takes sync-generator timing and emits
// RGB pixels aligned to de, with all outputs delayed by exactly two pclk cycles.
module video_pattern_generator #(
  parameter int    DATA_WIDTH   = 8,
  parameter int    H_ACTIVE     = 1920,
  parameter int    V_ACTIVE     = 1080,
  parameter string SYNC_NEGATED = "FALSE"
) (
  input  logic                  pclk,
  input  logic                  rst_n,
  input  logic [2:0]            pattern_sel,
  input  logic                  in_vsync,
  input  logic                  in_hsync,
  input  logic                  in_de,
  input  logic                  in_field,
  output logic                  out_vsync,
  output logic                  out_hsync,
  output logic                  out_de,
  output logic                  out_field,
  output logic [DATA_WIDTH-1:0] r,
  output logic [DATA_WIDTH-1:0] g,
  output logic [DATA_WIDTH-1:0] b
);

  localparam logic                  NEG      = (SYNC_NEGATED == "TRUE");
  localparam int                    BAR_W    = H_ACTIVE / 8;
  localparam logic [12:0]           BAR_LAST = 13'(BAR_W - 1);
  localparam logic [12:0]           X_LAST   = 13'(H_ACTIVE - 1);
  localparam logic [11:0]           Y_LAST   = 12'(V_ACTIVE - 1);
  localparam logic [DATA_WIDTH-1:0] FS       = '1;

  typedef enum logic [2:0] {
    PAT_BLACK   = 3'd0,
    PAT_BARS    = 3'd1,
    PAT_RAMP    = 3'd2,
    PAT_CHECKER = 3'd3,
    PAT_LINE    = 3'd4,
    PAT_BORDER  = 3'd5,
    PAT_RSVD6   = 3'd6,
    PAT_RSVD7   = 3'd7
  } pat_e;

  // Stage 1: re-timed inputs and pixel coordinates
  logic        vs1_q, vs1_d, hs1_q, hs1_d, de1_q, de1_d, fld1_q, fld1_d;
  logic [12:0] x_q, x_d, bar_px_q, bar_px_d;
  logic [11:0] y_q, y_d;
  logic [7:0]  frame_q, frame_d;
  logic [2:0]  bar_idx_q, bar_idx_d;
  pat_e        sel_q, sel_d;

  // Stage 2: output registers
  logic                  vs2_q, vs2_d, hs2_q, hs2_d, de2_q, de2_d, fld2_q, fld2_d;
  logic [DATA_WIDTH-1:0] r_q, r_d, g_q, g_d, b_q, b_d;

  logic                  fs, de_run, de_fall, fld_chg;
  logic [2:0]            mask;
  logic                  use_ramp;
  logic [DATA_WIDTH-1:0] pix_r, pix_g, pix_b;

  always_comb begin
    fs      = (in_vsync ^ NEG) & ~(vs1_q ^ NEG);
    de_run  = in_de & de1_q;
    de_fall = de1_q & ~in_de;
    fld_chg = in_field ^ fld1_q;

    vs1_d   = in_vsync;
    hs1_d   = in_hsync;
    de1_d   = in_de;
    fld1_d  = in_field;

    x_d     = de_run ? x_q + 13'd1 : 13'd0;

    // A frame start or field change outranks a coincident de fall
    if (fs || fld_chg) begin
      y_d = 12'd0;
    end else if (de_fall) begin
      y_d = y_q + 12'd1;
    end else begin
      y_d = y_q;
    end

    frame_d = fs ? frame_q + 8'd1 : frame_q;
    sel_d   = fs ? pat_e'(pattern_sel) : sel_q;

    bar_px_d  = 13'd0;
    bar_idx_d = 3'd0;
    if (de_run) begin
      bar_idx_d = bar_idx_q;
      if (bar_px_q == BAR_LAST) begin
        if (bar_idx_q != 3'd7) bar_idx_d = bar_idx_q + 3'd1;
      end else begin
        bar_px_d = bar_px_q + 13'd1;
      end
    end
  end

  // Pixel compute works on the stage-1 coordinates; mask bits are {r,g,b}
  always_comb begin
    mask     = 3'b000;
    use_ramp = 1'b0;
    case (sel_q)
      PAT_BARS: begin
        case (bar_idx_q)
          3'd0:    mask = 3'b111;
          3'd1:    mask = 3'b110;
          3'd2:    mask = 3'b011;
          3'd3:    mask = 3'b010;
          3'd4:    mask = 3'b101;
          3'd5:    mask = 3'b100;
          3'd6:    mask = 3'b001;
          default: mask = 3'b000;
        endcase
      end
      PAT_RAMP:    use_ramp = 1'b1;
      PAT_CHECKER: mask = {3{x_q[6] ^ y_q[6]}};
      PAT_LINE:    mask = {3{x_q[7:0] == frame_q}};
      PAT_BORDER:  mask = {3{(x_q == 13'd0) || (x_q == X_LAST) ||
                             (y_q == 12'd0) || (y_q == Y_LAST)}};
      default:     mask = 3'b000;
    endcase

    if (use_ramp) begin
      pix_r = x_q[DATA_WIDTH-1:0];
      pix_g = x_q[DATA_WIDTH-1:0];
      pix_b = x_q[DATA_WIDTH-1:0];
    end else begin
      pix_r = mask[2] ? FS : '0;
      pix_g = mask[1] ? FS : '0;
      pix_b = mask[0] ? FS : '0;
    end

    vs2_d  = vs1_q;
    hs2_d  = hs1_q;
    de2_d  = de1_q;
    fld2_d = fld1_q;
    r_d    = de1_q ? pix_r : '0;
    g_d    = de1_q ? pix_g : '0;
    b_d    = de1_q ? pix_b : '0;
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vs1_q     <= NEG;
      hs1_q     <= NEG;
      de1_q     <= 1'b0;
      fld1_q    <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      frame_q   <= '0;
      sel_q     <= PAT_BLACK;
      bar_px_q  <= '0;
      bar_idx_q <= '0;
      vs2_q     <= NEG;
      hs2_q     <= NEG;
      de2_q     <= 1'b0;
      fld2_q    <= 1'b0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
    end else begin
      vs1_q     <= vs1_d;
      hs1_q     <= hs1_d;
      de1_q     <= de1_d;
      fld1_q    <= fld1_d;
      x_q       <= x_d;
      y_q       <= y_d;
      frame_q   <= frame_d;
      sel_q     <= sel_d;
      bar_px_q  <= bar_px_d;
      bar_idx_q <= bar_idx_d;
      vs2_q     <= vs2_d;
      hs2_q     <= hs2_d;
      de2_q     <= de2_d;
      fld2_q    <= fld2_d;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
    end
  end

  assign out_vsync = vs2_q;
  assign out_hsync = hs2_q;
  assign out_de    = de2_q;
  assign out_field = fld2_q;
  assign r         = r_q;
  assign g         = g_q;
  assign b         = b_q;

endmodule
